// File: rtl/tamagotchi_need_fsm.sv
// Pet-state engine: N saturating need levels decaying on a shared prescaled tick,
// replenished by button presses, with a mood FSM driven by the lowest level.
module tamagotchi_need_fsm #(
  parameter int NUM_NEEDS   = 4,
  parameter int LVL_W       = 3,
  parameter int STEP        = 2,
  parameter int DECAY_DIV   = 50_000_000,
  parameter int TEST_DIV    = 5_000_000,
  parameter int HI_TH       = 5,
  parameter int LO_TH       = 3,
  parameter int DEATH_TICKS = 3,
  localparam int IDX_W      = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1
) (
  input  logic                       clk,
  input  logic                       btn_reset,
  input  logic                       btn_test,
  input  logic [NUM_NEEDS-1:0]       btn_need,
  output logic [NUM_NEEDS*LVL_W-1:0] levels,
  output logic [IDX_W-1:0]           worst_need,
  output logic [2:0]                 display_out,
  output logic                       test_mode,
  output logic                       decay_tick
);

  localparam int PRE_W = $clog2(DECAY_DIV);
  localparam int CNT_W = $clog2(DEATH_TICKS + 1);
  localparam logic [PRE_W-1:0] DECAY_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PRE_W-1:0] TEST_LAST  = PRE_W'(TEST_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_MAX    = {LVL_W{1'b1}};

  typedef enum logic [2:0] {
    ST_HAPPY = 3'd0,
    ST_OK    = 3'd1,
    ST_NEEDY = 3'd2,
    ST_CRIT  = 3'd3,
    ST_DEAD  = 3'd4
  } mood_e;

  logic [NUM_NEEDS-1:0] btn_q;
  logic                 btn_test_q;
  logic [NUM_NEEDS-1:0] press;
  logic                 test_edge;
  logic                 test_mode_q, test_mode_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [PRE_W-1:0]     presc_last;
  logic                 tick;
  mood_e                state_q, state_d;
  mood_e                level_mood;
  logic [CNT_W-1:0]     death_q, death_d;
  logic [IDX_W-1:0]     worst_q, worst_d;
  logic [LVL_W-1:0]     min_lvl;

  assign press     = btn_need & ~btn_q;
  assign test_edge = btn_test & ~btn_test_q;

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      btn_q       <= '0;
      btn_test_q  <= 1'b0;
      test_mode_q <= 1'b0;
      presc_q     <= '0;
    end else begin
      btn_q       <= btn_need;
      btn_test_q  <= btn_test;
      test_mode_q <= test_mode_d;
      presc_q     <= presc_d;
    end
  end

  // A mode toggle restarts the prescaler and swallows any tick due that cycle.
  always_comb begin
    presc_last  = test_mode_q ? TEST_LAST : DECAY_LAST;
    test_mode_d = test_mode_q;
    presc_d     = presc_q + PRE_W'(1);
    tick        = 1'b0;
    if (test_edge) begin
      test_mode_d = ~test_mode_q;
      presc_d     = '0;
    end else if (presc_q == presc_last) begin
      presc_d = '0;
      tick    = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_need
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W:0]   sum;

    always_comb begin
      sum = {1'b0, level_q};
      if (press[gi]) sum = sum + (LVL_W + 1)'(STEP);
      if (tick && (sum != '0)) sum = sum - (LVL_W + 1)'(1);
      level_d = (sum > {1'b0, LVL_MAX}) ? LVL_MAX : sum[LVL_W-1:0];
      if (state_q == ST_DEAD) level_d = level_q;
    end

    always_ff @(posedge clk) begin
      if (btn_reset) level_q <= LVL_MAX;
      else           level_q <= level_d;
    end

    assign levels[gi*LVL_W +: LVL_W] = level_q;
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_lvl = levels[LVL_W-1:0];
    worst_d = '0;
    for (int i = 1; i < NUM_NEEDS; i++) begin
      if (levels[i*LVL_W +: LVL_W] < min_lvl) begin
        min_lvl = levels[i*LVL_W +: LVL_W];
        worst_d = IDX_W'(i);
      end
    end
  end

  always_comb begin
    if (min_lvl >= LVL_W'(HI_TH))      level_mood = ST_HAPPY;
    else if (min_lvl >= LVL_W'(LO_TH)) level_mood = ST_OK;
    else if (min_lvl != '0)            level_mood = ST_NEEDY;
    else                               level_mood = ST_CRIT;
  end

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      state_q <= ST_HAPPY;
      death_q <= '0;
      worst_q <= '0;
    end else begin
      state_q <= state_d;
      death_q <= death_d;
      worst_q <= worst_d;
    end
  end

  always_comb begin
    state_d = level_mood;
    death_d = '0;
    if (state_q == ST_DEAD) begin
      state_d = ST_DEAD;
      death_d = death_q;
    end else if (level_mood == ST_CRIT) begin
      death_d = death_q;
      if (tick) begin
        death_d = death_q + CNT_W'(1);
        if (death_d == CNT_W'(DEATH_TICKS)) state_d = ST_DEAD;
      end
    end
  end

  always_comb begin
    display_out = state_q;
    worst_need  = worst_q;
    test_mode   = test_mode_q;
    decay_tick  = tick;
  end

endmodule

// File: tb/tb_tamagotchi_need_fsm.sv
// Directed bench for tamagotchi_need_fsm: decay, presses, clamping, test mode,
// death and reset-from-dead, with hand-derived expectations per clock.
module tb_tamagotchi_need_fsm;

  logic        clk = 1'b0;
  logic        btn_reset;
  logic        btn_test;
  logic [3:0]  btn_need;
  logic [11:0] levels;
  logic [1:0]  worst_need;
  logic [2:0]  display_out;
  logic        test_mode;
  logic        decay_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tamagotchi_need_fsm #(
    .NUM_NEEDS(4), .LVL_W(3), .STEP(2), .DECAY_DIV(4), .TEST_DIV(2),
    .HI_TH(5), .LO_TH(3), .DEATH_TICKS(3)
  ) dut (
    .clk(clk),
    .btn_reset(btn_reset),
    .btn_test(btn_test),
    .btn_need(btn_need),
    .levels(levels),
    .worst_need(worst_need),
    .display_out(display_out),
    .test_mode(test_mode),
    .decay_tick(decay_tick)
  );

  function automatic logic [11:0] all_lvl(input int v);
    logic [2:0] l;
    l = 3'(v);
    return {l, l, l, l};
  endfunction

  function automatic logic [2:0] mood_of(input int l);
    if (l >= 5) return 3'd0;
    if (l >= 3) return 3'd1;
    if (l >= 1) return 3'd2;
    return 3'd3;
  endfunction

  // Leaves the bench at the negedge right after the reset edge (prescaler at 0).
  task automatic do_reset;
    btn_reset = 1'b1;
    btn_test  = 1'b0;
    btn_need  = 4'b0000;
    @(negedge clk);
    btn_reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (levels !== all_lvl(7)) begin n_fail++; $display("FAIL reset_levels: got %h want %h", levels, all_lvl(7)); end
    n_checks++; if (display_out !== 3'd0) begin n_fail++; $display("FAIL reset_display: got %0d want 0", display_out); end
    n_checks++; if (worst_need !== 2'd0) begin n_fail++; $display("FAIL reset_worst: got %0d want 0", worst_need); end
    n_checks++; if (test_mode !== 1'b0) begin n_fail++; $display("FAIL reset_test_mode: got %b want 0", test_mode); end
    n_checks++; if (decay_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", decay_tick); end
    $display("test_reset: levels=%h display=%0d", levels, display_out);
  endtask

  task automatic test_decay;
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      n_checks++; if (decay_tick !== 1'((n % 4) == 3)) begin n_fail++; $display("FAIL decay_tick cyc%0d: got %b want %b", n, decay_tick, (n % 4) == 3); end
      n_checks++; if (levels !== all_lvl(7 - n / 4)) begin n_fail++; $display("FAIL decay_levels cyc%0d: got %h want %h", n, levels, all_lvl(7 - n / 4)); end
      n_checks++; if (display_out !== mood_of(7 - (n - 1) / 4)) begin n_fail++; $display("FAIL decay_display cyc%0d: got %0d want %0d", n, display_out, mood_of(7 - (n - 1) / 4)); end
    end
    n_checks++; if (worst_need !== 2'd0) begin n_fail++; $display("FAIL decay_worst: got %0d want 0", worst_need); end
    $display("test_decay: levels=%h display=%0d", levels, display_out);
  endtask

  task automatic test_hold_press;
    do_reset();
    repeat (17) @(negedge clk);
    btn_need = 4'b1011;
    @(negedge clk);
    n_checks++; if (levels !== {3'd5, 3'd3, 3'd5, 3'd5}) begin n_fail++; $display("FAIL hold_others: got %h want %h", levels, {3'd5, 3'd3, 3'd5, 3'd5}); end
    n_checks++; if (worst_need !== 2'd0) begin n_fail++; $display("FAIL hold_worst_pre: got %0d want 0", worst_need); end
    btn_need = 4'b0100;
    @(negedge clk);
    n_checks++; if (levels !== all_lvl(5)) begin n_fail++; $display("FAIL hold_hambre5: got %h want %h", levels, all_lvl(5)); end
    n_checks++; if (worst_need !== 2'd2) begin n_fail++; $display("FAIL hold_worst2: got %0d want 2", worst_need); end
    n_checks++; if (decay_tick !== 1'b1) begin n_fail++; $display("FAIL hold_tick: got %b want 1", decay_tick); end
    @(negedge clk);
    n_checks++; if (worst_need !== 2'd0) begin n_fail++; $display("FAIL hold_worst_off: got %0d want 0", worst_need); end
    n_checks++; if (levels !== all_lvl(4)) begin n_fail++; $display("FAIL hold_after_tick: got %h want %h", levels, all_lvl(4)); end
    n_checks++; if (display_out !== 3'd0) begin n_fail++; $display("FAIL hold_display: got %0d want 0", display_out); end
    repeat (8) @(negedge clk);
    n_checks++; if (levels !== all_lvl(2)) begin n_fail++; $display("FAIL hold_single_count: got %h want %h", levels, all_lvl(2)); end
    btn_need = 4'b0000;
    $display("test_hold_press: levels=%h worst=%0d", levels, worst_need);
  endtask

  task automatic test_clamp;
    do_reset();
    repeat (7) @(negedge clk);
    n_checks++; if (decay_tick !== 1'b1) begin n_fail++; $display("FAIL clamp_tick: got %b want 1", decay_tick); end
    btn_need = 4'b0001;
    @(negedge clk);
    n_checks++; if (levels !== {3'd5, 3'd5, 3'd5, 3'd7}) begin n_fail++; $display("FAIL clamp_press_tick: got %h want %h", levels, {3'd5, 3'd5, 3'd5, 3'd7}); end
    btn_need = 4'b0000;
    @(negedge clk);
    btn_need = 4'b0001;
    @(negedge clk);
    n_checks++; if (levels !== {3'd5, 3'd5, 3'd5, 3'd7}) begin n_fail++; $display("FAIL clamp_at_max: got %h want %h", levels, {3'd5, 3'd5, 3'd5, 3'd7}); end
    btn_need = 4'b0000;
    $display("test_clamp: levels=%h", levels);
  endtask

  task automatic test_test_mode;
    do_reset();
    repeat (3) @(negedge clk);
    btn_test = 1'b1;
    #1;
    n_checks++; if (decay_tick !== 1'b0) begin n_fail++; $display("FAIL tm_tick_suppressed1: got %b want 0", decay_tick); end
    @(negedge clk);
    n_checks++; if (test_mode !== 1'b1) begin n_fail++; $display("FAIL tm_enter: got %b want 1", test_mode); end
    n_checks++; if (levels !== all_lvl(7)) begin n_fail++; $display("FAIL tm_no_decay: got %h want %h", levels, all_lvl(7)); end
    for (int n = 5; n <= 9; n++) begin
      @(negedge clk);
      n_checks++; if (decay_tick !== 1'((n % 2) == 1)) begin n_fail++; $display("FAIL tm_fast_tick cyc%0d: got %b want %b", n, decay_tick, (n % 2) == 1); end
      if (n == 6) btn_test = 1'b0;
    end
    n_checks++; if (levels !== all_lvl(5)) begin n_fail++; $display("FAIL tm_fast_levels: got %h want %h", levels, all_lvl(5)); end
    btn_test = 1'b1;
    #1;
    n_checks++; if (decay_tick !== 1'b0) begin n_fail++; $display("FAIL tm_tick_suppressed2: got %b want 0", decay_tick); end
    @(negedge clk);
    n_checks++; if (test_mode !== 1'b0) begin n_fail++; $display("FAIL tm_exit: got %b want 0", test_mode); end
    n_checks++; if (levels !== all_lvl(5)) begin n_fail++; $display("FAIL tm_exit_levels: got %h want %h", levels, all_lvl(5)); end
    btn_test = 1'b0;
    for (int n = 11; n <= 17; n++) begin
      @(negedge clk);
      n_checks++; if (decay_tick !== 1'(n == 13 || n == 17)) begin n_fail++; $display("FAIL tm_slow_tick cyc%0d: got %b want %b", n, decay_tick, n == 13 || n == 17); end
    end
    n_checks++; if (levels !== all_lvl(4)) begin n_fail++; $display("FAIL tm_slow_levels: got %h want %h", levels, all_lvl(4)); end
    $display("test_test_mode: test_mode=%b levels=%h", test_mode, levels);
  endtask

  task automatic test_death;
    do_reset();
    repeat (28) @(negedge clk);
    n_checks++; if (levels !== all_lvl(0)) begin n_fail++; $display("FAIL death_empty: got %h want %h", levels, all_lvl(0)); end
    @(negedge clk);
    n_checks++; if (display_out !== 3'd3) begin n_fail++; $display("FAIL death_critical: got %0d want 3", display_out); end
    repeat (10) @(negedge clk);
    n_checks++; if (display_out !== 3'd3) begin n_fail++; $display("FAIL death_still_critical: got %0d want 3", display_out); end
    @(negedge clk);
    n_checks++; if (display_out !== 3'd4) begin n_fail++; $display("FAIL death_dead: got %0d want 4", display_out); end
    btn_need = 4'b1111;
    @(negedge clk);
    n_checks++; if (levels !== all_lvl(0)) begin n_fail++; $display("FAIL dead_press_levels: got %h want %h", levels, all_lvl(0)); end
    n_checks++; if (display_out !== 3'd4) begin n_fail++; $display("FAIL dead_press_display: got %0d want 4", display_out); end
    btn_need = 4'b0000;
    repeat (8) @(negedge clk);
    n_checks++; if (levels !== all_lvl(0)) begin n_fail++; $display("FAIL dead_frozen: got %h want %h", levels, all_lvl(0)); end
    n_checks++; if (display_out !== 3'd4) begin n_fail++; $display("FAIL dead_sticky: got %0d want 4", display_out); end
    $display("test_death: display=%0d levels=%h", display_out, levels);
  endtask

  task automatic test_dead_reset;
    btn_test = 1'b1;
    @(negedge clk);
    n_checks++; if (test_mode !== 1'b1) begin n_fail++; $display("FAIL dead_tm_toggle: got %b want 1", test_mode); end
    n_checks++; if (display_out !== 3'd4) begin n_fail++; $display("FAIL dead_tm_display: got %0d want 4", display_out); end
    btn_test = 1'b0;
    @(negedge clk);
    n_checks++; if (decay_tick !== 1'b1) begin n_fail++; $display("FAIL dead_tm_tick: got %b want 1", decay_tick); end
    btn_reset = 1'b1;
    @(negedge clk);
    btn_reset = 1'b0;
    n_checks++; if (levels !== all_lvl(7)) begin n_fail++; $display("FAIL revive_levels: got %h want %h", levels, all_lvl(7)); end
    n_checks++; if (display_out !== 3'd0) begin n_fail++; $display("FAIL revive_display: got %0d want 0", display_out); end
    n_checks++; if (test_mode !== 1'b0) begin n_fail++; $display("FAIL revive_test_mode: got %b want 0", test_mode); end
    n_checks++; if (decay_tick !== 1'b0) begin n_fail++; $display("FAIL revive_tick: got %b want 0", decay_tick); end
    $display("test_dead_reset: levels=%h display=%0d test_mode=%b", levels, display_out, test_mode);
  endtask

  initial begin
    btn_reset = 1'b1;
    btn_test  = 1'b0;
    btn_need  = 4'b0000;
    test_reset();
    test_decay();
    test_hold_press();
    test_clamp();
    test_test_mode();
    test_death();
    test_dead_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
